spi_slave_bridge: RTL and testbench

//  SPI mode-0 slave (CPOL=0, CPHA=0, MSB first, 8-bit frames) bridging an external SPI master to the internal spi_bus.

---
 rtl/spi_slave_bridge.sv | 104 ++++++++++
 tb/tb_spi_slave_bridge.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_bridge.sv
// SPI mode-0 slave bridging an external master onto the internal byte bus.
// Optional SPI_MISO_HIZ_EN: tri-states spi_miso while spi_cs is high.
module spi_slave_bridge #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       spi_clk,
  input  logic       spi_cs,
  input  logic       spi_mosi,
  output logic       spi_miso,
  output logic [7:0] data_read,
  output logic       read_valid,
  input  logic [7:0] data_write,
  output logic       can_write
);

  localparam int unsigned Stages = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

  // spi_clk domain state
  logic [2:0] bit_cnt;
  logic [7:0] rx_shift;
  logic [7:0] rx_hold;
  logic [7:0] tx_byte;
  logic       rx_tgl;
  logic       tx_tgl;
  logic       cnt_clr;
  logic       miso_int;

  // clk domain state
  logic [Stages-1:0] rx_sync;
  logic [Stages-1:0] tx_sync;
  logic              rx_seen;
  logic              tx_seen;
  logic              rx_evt;
  logic              tx_evt;

  // Deasserting chip select aborts the frame: the bit counter restarts at the next byte.
  assign cnt_clr = rst | spi_cs;

  always_ff @(posedge spi_clk or posedge cnt_clr) begin
    if (cnt_clr) begin
      bit_cnt <= 3'd0;
    end else begin
      bit_cnt <= bit_cnt + 3'd1;
    end
  end

  always_ff @(posedge spi_clk or posedge rst) begin
    if (rst) begin
      rx_shift <= 8'h00;
      rx_hold  <= 8'h00;
      rx_tgl   <= 1'b0;
      tx_byte  <= 8'h00;
      tx_tgl   <= 1'b0;
    end else if (!spi_cs) begin
      rx_shift <= {rx_shift[6:0], spi_mosi};
      if (bit_cnt == 3'd7) begin
        rx_hold <= {rx_shift[6:0], spi_mosi};
        rx_tgl  <= ~rx_tgl;
      end
      if (bit_cnt == 3'd0) begin
        tx_byte <= data_write;
        tx_tgl  <= ~tx_tgl;
      end
    end
  end

  // Bit 7 comes straight from the bus so it is valid before the first rising edge.
  assign miso_int = (bit_cnt == 3'd0) ? data_write[7] : tx_byte[3'd7 - bit_cnt];

`ifdef SPI_MISO_HIZ_EN
  assign spi_miso = spi_cs ? 1'bz : miso_int;
`else
  assign spi_miso = miso_int;
`endif

  assign rx_evt = rx_sync[Stages-1] ^ rx_seen;
  assign tx_evt = tx_sync[Stages-1] ^ tx_seen;

  // rx_hold is quiet for seven spi_clk periods after rx_tgl flips, so it is sampled directly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_sync    <= '0;
      tx_sync    <= '0;
      rx_seen    <= 1'b0;
      tx_seen    <= 1'b0;
      read_valid <= 1'b0;
      can_write  <= 1'b0;
      data_read  <= 8'h00;
    end else begin
      rx_sync    <= {rx_sync[Stages-2:0], rx_tgl};
      tx_sync    <= {tx_sync[Stages-2:0], tx_tgl};
      rx_seen    <= rx_sync[Stages-1];
      tx_seen    <= tx_sync[Stages-1];
      read_valid <= rx_evt;
      can_write  <= tx_evt;
      if (rx_evt) begin
        data_read <= rx_hold;
      end
    end
  end

endmodule

// File: tb/tb_spi_slave_bridge.sv
// Scoreboard bench for spi_slave_bridge: master model on spi_*, bus model on data_write.
`timescale 1ns/1ps
module tb_spi_slave_bridge;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       spi_clk = 1'b0;
  logic       spi_cs = 1'b1;
  logic       spi_mosi = 1'b0;
  logic       spi_miso;
  logic [7:0] data_read;
  logic       read_valid;
  logic [7:0] data_write = 8'h00;
  logic       can_write;

  int n_cmp = 0;
  int n_bad = 0;
  int rv_cnt = 0;
  int cw_cnt = 0;
  int tx_idx = 0;
  bit bus_en = 1'b0;
  logic [7:0] rx_q[$];
  logic [7:0] tx_q[$];
  logic [7:0] txb[8];

  spi_slave_bridge #(.SYNC_STAGES(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .spi_clk   (spi_clk),
    .spi_cs    (spi_cs),
    .spi_mosi  (spi_mosi),
    .spi_miso  (spi_miso),
    .data_read (data_read),
    .read_valid(read_valid),
    .data_write(data_write),
    .can_write (can_write)
  );

  always #250 clk = ~clk;

  task automatic check_eq(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Bus-side monitor: pops the rx scoreboard on each strobe, feeds the next tx byte on can_write.
  always @(negedge clk) begin
    if (read_valid === 1'b1) begin
      rv_cnt++;
      check_eq("rv_expected", 8'(rx_q.size() > 0), 8'd1);
      if (rx_q.size() > 0) check_eq("rx_data", data_read, rx_q.pop_front());
    end
    if (can_write === 1'b1) begin
      cw_cnt++;
      if (bus_en && tx_idx < 7) begin
        tx_idx++;
        data_write = txb[tx_idx];
      end
    end
  end

  task automatic spi_bits(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
    rx = 8'h00;
    for (int i = 7; i > 7 - nbits; i--) begin
      spi_mosi = tx[i];
      #200;
      rx[i] = spi_miso;
      #50 spi_clk = 1'b1;
      #250 spi_clk = 1'b0;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    logic [7:0] r;
    rx_q.push_back(b);
    spi_bits(b, 8, r);
  endtask

  task automatic drain(input string tag);
    repeat (6) @(posedge clk);
    for (int k = 0; k < 20 && rx_q.size() != 0; k++) @(posedge clk);
    check_eq(tag, 8'(rx_q.size()), 8'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] r;
    logic [7:0] b;
    int base_rv;
    int base_cw;

    repeat (3) @(negedge clk);
    check_eq("rst_data_read", data_read, 8'h00);
    check_eq("rst_read_valid", {7'b0, read_valid}, 8'h00);
    check_eq("rst_can_write", {7'b0, can_write}, 8'h00);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    spi_cs = 1'b0;
    #100;

    // 1: single command byte
    send_byte(8'h53);
    drain("t1_drain");
    check_eq("t1_strobes", 8'(rv_cnt), 8'd1);

    // 2: burst of 9 bytes back-to-back
    base_rv = rv_cnt;
    send_byte(8'h53);
    for (int k = 0; k < 8; k++) send_byte(8'($urandom));
    drain("t2_drain");
    check_eq("t2_strobes", 8'(rv_cnt - base_rv), 8'd9);

    // 3: full-duplex transmit, bus refills data_write on each can_write
    for (int k = 0; k < 8; k++) begin
      txb[k] = 8'($urandom);
      tx_q.push_back(txb[k]);
    end
    tx_idx = 0;
    data_write = txb[0];
    bus_en = 1'b1;
    repeat (2) @(posedge clk);
    for (int k = 0; k < 8; k++) begin
      b = 8'($urandom);
      rx_q.push_back(b);
      spi_bits(b, 8, r);
      check_eq("miso_byte", r, tx_q.pop_front());
    end
    drain("t3_drain");
    bus_en = 1'b0;

    // 4: aborted partial frame, then a full byte
    base_rv = rv_cnt;
    spi_bits(8'hC3, 4, r);
    spi_cs = 1'b1;
    #500 spi_cs = 1'b0;
    #250;
    send_byte(8'hA5);
    drain("t4_drain");
    check_eq("t4_strobes", 8'(rv_cnt - base_rv), 8'd1);
    check_eq("t4_data", data_read, 8'hA5);

    // 5: reset in the middle of a byte
    spi_bits(8'hFF, 4, r);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("t5_data_read", data_read, 8'h00);
    check_eq("t5_read_valid", {7'b0, read_valid}, 8'h00);
    check_eq("t5_can_write", {7'b0, can_write}, 8'h00);
    spi_cs = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    spi_cs = 1'b0;
    #250;
    base_rv = rv_cnt;
    send_byte(8'h6B);
    drain("t5_drain");
    check_eq("t5_strobes", 8'(rv_cnt - base_rv), 8'd1);
    check_eq("t5_data", data_read, 8'h6B);

    // 6: idle bus, spi_clk toggling with chip select high
    data_write = 8'h00;
    spi_cs = 1'b1;
    #250;
    repeat (4) @(posedge clk);
    base_rv = rv_cnt;
    base_cw = cw_cnt;
    for (int k = 0; k < 16; k++) begin
      spi_mosi = 1'($urandom);
      #250 spi_clk = 1'b1;
      #250 spi_clk = 1'b0;
    end
`ifdef SPI_MISO_HIZ_EN
    check_eq("t6_miso", {7'b0, spi_miso}, {7'b0, 1'bz});
`else
    check_eq("t6_miso", {7'b0, spi_miso}, 8'h00);
`endif
    repeat (8) @(posedge clk);
    check_eq("t6_read_valid", 8'(rv_cnt - base_rv), 8'd0);
    check_eq("t6_can_write", 8'(cw_cnt - base_cw), 8'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
